// File: rtl/regfile_wb_pkg.sv
// Shared write-back / register-file definitions.
// Widths, the upstream write-back select encodings and the register count.
package regfile_wb_pkg;

   localparam int RF_DATA_W = 16;
   localparam int RF_ADDR_W = 3;
   localparam int RF_CNT_W  = 16;
   localparam int RF_NREGS  = 2 ** RF_ADDR_W;

   // Select encodings of the mux that feeds wb_data.
   typedef enum logic [1:0] {
      WB_SEL_ALU  = 2'b00,
      WB_SEL_MEM  = 2'b01,
      WB_SEL_PC1  = 2'b10,
      WB_SEL_RSVD = 2'b11
   } wb_sel_e;

endpackage

// File: rtl/regfile_wb_if.sv
// Write-back request channel: valid/ready handshake with address and data.
// master = mux side (drives valid/addr/data), slave = register file side (drives ready).
interface regfile_wb_if #(
   parameter int ADDR_W = 3,
   parameter int DATA_W = 16
);
   logic              wb_valid;
   logic              wb_ready;
   logic [ADDR_W-1:0] wb_addr;
   logic [DATA_W-1:0] wb_data;

   modport master (
      output wb_valid,
      output wb_addr,
      output wb_data,
      input  wb_ready
   );

   modport slave (
      input  wb_valid,
      input  wb_addr,
      input  wb_data,
      output wb_ready
   );
endinterface

// File: rtl/regfile_array.sv
// 2**ADDR_W x DATA_W register storage: one synchronous write, two async reads.
// Ports: clk, rst (sync, high), i_we/i_waddr/i_wdata, i_raddr_x -> o_rdata_x. r0 reads 0.
module regfile_array
   import regfile_wb_pkg::*;
#(
   parameter int DATA_W = RF_DATA_W,
   parameter int ADDR_W = RF_ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic [ADDR_W-1:0] i_raddr_a,
   output logic [DATA_W-1:0] o_rdata_a,
   input  logic [ADDR_W-1:0] i_raddr_b,
   output logic [DATA_W-1:0] o_rdata_b
);

   localparam int NREGS = 2 ** ADDR_W;

   logic [DATA_W-1:0] r_mem [NREGS];

   // Entry 0 is never written, so it stays at its reset value.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) begin
            r_mem[i] <= '0;
         end
      end else if (i_we && (i_waddr != '0)) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata_a = (i_raddr_a == '0) ? '0 : r_mem[i_raddr_a];
   assign o_rdata_b = (i_raddr_b == '0) ? '0 : r_mem[i_raddr_b];

endmodule

// File: rtl/regfile_wb.sv
// Write-back stage: handshake, one-entry pending register, commit counter, array.
// Ports: clk, rst (sync, high), wb (slave channel), hold, rd_addr_a/b -> rd_data_a/b,
// hazard_a/b, retire_cnt. Define REGFILE_WB_FORWARD_EN to forward pending data to reads.
module regfile_wb
   import regfile_wb_pkg::*;
#(
   parameter int DATA_W = RF_DATA_W,
   parameter int ADDR_W = RF_ADDR_W,
   parameter int CNT_W  = RF_CNT_W
) (
   input  logic              clk,
   input  logic              rst,
   regfile_wb_if.slave       wb,
   input  logic              hold,
   input  logic [ADDR_W-1:0] rd_addr_a,
   output logic [DATA_W-1:0] rd_data_a,
   input  logic [ADDR_W-1:0] rd_addr_b,
   output logic [DATA_W-1:0] rd_data_b,
   output logic              hazard_a,
   output logic              hazard_b,
   output logic [CNT_W-1:0]  retire_cnt
);

   logic              r_pend_v;
   logic [ADDR_W-1:0] r_pend_a;
   logic [DATA_W-1:0] r_pend_d;
   logic [CNT_W-1:0]  r_cnt;

   logic              w_accept;
   logic              w_commit;
   logic              w_hit_a;
   logic              w_hit_b;
   logic [DATA_W-1:0] w_arr_a;
   logic [DATA_W-1:0] w_arr_b;

   // A held entry blocks the slot; an empty slot can always take one write.
   assign wb.wb_ready = !r_pend_v || !hold;
   assign w_accept    = wb.wb_valid && wb.wb_ready;
   assign w_commit    = r_pend_v && !hold;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pend_v <= 1'b0;
         r_pend_a <= '0;
         r_pend_d <= '0;
         r_cnt    <= '0;
      end else begin
         if (w_commit) begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
         // Reload on the commit edge keeps one write per cycle.
         if (w_accept) begin
            r_pend_v <= 1'b1;
            r_pend_a <= wb.wb_addr;
            r_pend_d <= wb.wb_data;
         end else if (w_commit) begin
            r_pend_v <= 1'b0;
         end
      end
   end

   regfile_array #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_array (
      .clk       (clk),
      .rst       (rst),
      .i_we      (w_commit),
      .i_waddr   (r_pend_a),
      .i_wdata   (r_pend_d),
      .i_raddr_a (rd_addr_a),
      .o_rdata_a (w_arr_a),
      .i_raddr_b (rd_addr_b),
      .o_rdata_b (w_arr_b)
   );

   // r0 never conflicts: it reads 0 whatever is pending.
   assign w_hit_a = r_pend_v && (rd_addr_a == r_pend_a) && (rd_addr_a != '0);
   assign w_hit_b = r_pend_v && (rd_addr_b == r_pend_a) && (rd_addr_b != '0);

`ifdef REGFILE_WB_FORWARD_EN
   assign rd_data_a = w_hit_a ? r_pend_d : w_arr_a;
   assign rd_data_b = w_hit_b ? r_pend_d : w_arr_b;
   assign hazard_a  = 1'b0;
   assign hazard_b  = 1'b0;
`else
   assign rd_data_a = w_arr_a;
   assign rd_data_b = w_arr_b;
   assign hazard_a  = w_hit_a;
   assign hazard_b  = w_hit_b;
`endif

   assign retire_cnt = r_cnt;

endmodule

// File: doc/regfile_wb.md
Name: regfile_wb

Overview:
- Write-back stage and register file that sits directly downstream of the 3-input 16-bit write-back select mux.
- The mux output (ALU result / memory data / PC+1, chosen by a 2-bit select) arrives on wb_data with a destination address and a valid/ready handshake.
- Accepted writes pass through a one-entry pending register and are committed to an 8 x 16-bit array the following cycle.
- Two combinational read ports feed the operand path.

Parameters:
- DATA_W, 16, register and data width.
- ADDR_W, 3, register address width; NREGS = 2**ADDR_W.
- CNT_W, 16, width of retire counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- wb_valid  in  1  write request valid.
- wb_ready  out  1  stage can accept a write this cycle.
- wb_addr  in  ADDR_W  destination register.
- wb_data  in  DATA_W  write data (mux output).
- hold  in  1  freezes commit of the pending entry.
- rd_addr_a  in  ADDR_W  read port A address.
- rd_data_a  out  DATA_W  read port A data.
- rd_addr_b  in  ADDR_W  read port B address.
- rd_data_b  out  DATA_W  read port B data.
- hazard_a  out  1  port A address matches an uncommitted pending write.
- hazard_b  out  1  same for port B.
- retire_cnt  out  CNT_W  count of committed writes.

Behaviour:
- Reset (rst=1 at a clock edge): all array entries = 0, pending_valid = 0, pending_addr/data = 0, retire_cnt = 0. rst has priority over every other input. Reset mid-operation discards the pending entry without commit.
- Accept: the write is accepted when wb_valid && wb_ready at an edge; it lands in the pending register (pending_valid = 1).
- wb_ready = !pending_valid || !hold (combinational). Sources hold wb_addr/wb_data stable while wb_valid && !wb_ready.
- Commit: at each edge where pending_valid && !hold:
  - array[pending_addr] <= pending_data;
  - retire_cnt += 1, wrapping from 2**CNT_W-1 to 0;
  - pending_valid clears unless a new write is accepted on the same edge, in which case pending reloads (back-to-back throughput 1 write/cycle).
- Latency: accept at edge N, visible in the array after edge N+1 (with hold low).
- hold=1 with pending_valid=1: the entry is retained, wb_ready=0, and the counter does not increment. hold=1 with pending_valid=0: one write may still be accepted.
- Register 0 reads 0 always. A write to r0 is accepted and counted, but the array is not modified.
- Reads are combinational from the array (r0 forced to 0).
- hazard_x = pending_valid && (rd_addr_x == pending_addr) && (rd_addr_x != 0).
- Same-address back-to-back writes: the later one wins; each commit is counted.

Optional Feature:
- Macro: REGFILE_WB_FORWARD_EN.
- Defined: when hazard_x is true, rd_data_x returns pending_data (pending has priority over the array), and hazard_a/hazard_b are driven 0.
- Undefined: rd_data_x returns raw array contents, and hazard_a/hazard_b are driven as defined above so control can stall.

Decomposition:
- Shared definitions file cpu_defs (included):
  - DATA_W = 16, ADDR_W = 3;
  - the write-back select encodings used by the upstream mux: 2'b00 ALU, 2'b01 MEM, 2'b10 PC+1; 2'b11 reserved.
- One natural sub-module, regfile_array: 8 x 16 storage, one synchronous write port, two asynchronous read ports, r0 hardwired to zero.
- The handshake, pending register, forwarding and counter stay in regfile_wb.

Test Plan:
- Reset then read all 8 registers -> rd_data = 16'h0000, retire_cnt = 0, wb_ready = 1, hazards = 0.
- Write r3 = 16'h00A5 (hold=0), read r3 on port A:
  - cycle after accept: hazard_a=1 (forward off) or rd_data_a = 16'h00A5 with hazard_a=0 (forward on);
  - next cycle: rd_data_a = 16'h00A5 and retire_cnt = 1.
- Back-to-back writes r1 = 16'h0001, r1 = 16'h0002, r2 = 16'h0004 on three consecutive cycles -> wb_ready stays 1, final r1 = 16'h0002, r2 = 16'h0004, retire_cnt = 3.
- Write r5 = 16'h1234, then hold=1 for 4 cycles with wb_valid=1 for r6 = 16'h5678:
  - wb_ready = 0, r5 not committed, retire_cnt unchanged;
  - after hold drops: r5 commits, r6 is accepted on the same edge, then commits.
- Write r0 = 16'hFFFF -> read r0 = 0, retire_cnt increments by 1, no hazard flagged.
- Accept r4 = 16'hBEEF, assert rst on the next edge -> r4 reads 0, pending_valid = 0, retire_cnt = 0.
